// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Holds the receiver state encoding and the baud-to-cycle conversion.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    function automatic int cycles_per_symbol(input int system_clk, input int baudrate);
        return system_clk / baudrate;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// The reset value is a parameter so idle-high and idle-low lines both come up quiet.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            // NOTE: non-blocking so q takes the old meta value, giving two real flop stages.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rx_uart.sv
// 8N1 asynchronous serial receiver with a single-byte valid/ready holding register.
// Define RX_UART_PARITY_EN to receive 8E1 frames and report parity mismatches.
module rx_uart
    import uart_pkg::*;
#(
    parameter int SYSTEM_CLK = 100_000_000,
    parameter int BAUDRATE   = 9600
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_in,
    input  logic                 ready,
    output logic                 valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 frame_error,
    output logic                 overrun_error,
    output logic                 parity_error
);

    localparam int CPS   = cycles_per_symbol(SYSTEM_CLK, BAUDRATE);
    localparam int CW    = $clog2(CPS + 1);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CW-1:0]    HALF_LOAD = CW'(CPS / 2 - 1);
    localparam logic [CW-1:0]    FULL_LOAD = CW'(CPS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_e            state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IDX_W-1:0]     bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shift_reg, shift_n;
    logic                 expired;
    logic                 deliver;
    logic                 frame_err_n;
`ifdef RX_UART_PARITY_EN
    logic                 parity_bad, parity_bad_n;
    logic                 parity_err_n;
`endif

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx_in),
        .q     (rx_s)
    );

    assign expired = (cnt == '0);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_n     = state;
        cnt_n       = expired ? cnt : cnt - CW'(1);
        bit_idx_n   = bit_idx;
        shift_n     = shift_reg;
        deliver     = 1'b0;
        frame_err_n = 1'b0;
`ifdef RX_UART_PARITY_EN
        parity_bad_n = parity_bad;
        parity_err_n = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    cnt_n   = HALF_LOAD;
                    state_n = START;
                end
            end
            START: begin
                // A start bit that is already high again at mid-symbol was a glitch.
                if (expired) begin
                    if (rx_s) begin
                        state_n = IDLE;
                    end else begin
                        cnt_n     = FULL_LOAD;
                        bit_idx_n = '0;
                        state_n   = DATA;
                    end
                end
            end
            DATA: begin
                if (expired) begin
                    shift_n[bit_idx] = rx_s;
                    cnt_n            = FULL_LOAD;
                    if (bit_idx == LAST_IDX) begin
`ifdef RX_UART_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx + IDX_W'(1);
                    end
                end
            end
`ifdef RX_UART_PARITY_EN
            PARITY: begin
                if (expired) begin
                    parity_bad_n = (rx_s != ^shift_reg);
                    cnt_n        = FULL_LOAD;
                    state_n      = STOP;
                end
            end
`endif
            STOP: begin
                if (expired) begin
`ifdef RX_UART_PARITY_EN
                    parity_err_n = parity_bad;
`endif
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_n = IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = BREAK;
                    end
                end
            end
            BREAK: begin
                // Hold off until the line is released so a stuck-low line yields one error only.
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shift_reg <= shift_n;
        end
    end

`ifdef RX_UART_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_bad   <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            parity_bad   <= parity_bad_n;
            parity_error <= parity_err_n;
        end
    end
`else
    assign parity_error = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid         <= 1'b0;
            rx_data       <= '0;
            frame_error   <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            frame_error   <= frame_err_n;
            overrun_error <= 1'b0;
            if (deliver) begin
                // A byte consumed this same cycle frees the register for the new one.
                if (valid && !ready) begin
                    overrun_error <= 1'b1;
                end else begin
                    rx_data <= shift_reg;
                    valid   <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rx_uart.sv
// Self-checking bench for rx_uart at 10 clock cycles per symbol.
// Received bytes are compared against a queue of the bytes the bench serialised.
module tb_rx_uart;

    localparam int SYSTEM_CLK = 1_000_000;
    localparam int BAUDRATE   = 100_000;
    localparam int CPS        = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_in;
    logic       ready;
    logic       valid;
    logic [7:0] rx_data;
    logic       frame_error;
    logic       overrun_error;
    logic       parity_error;

    int n_checks = 0;
    int n_fail   = 0;

    int         valid_cycles;
    int         frame_cnt;
    int         overrun_cnt;
    int         parity_cnt;
    int         parity_total = 0;
    logic [7:0] got_q[$];

    rx_uart #(
        .SYSTEM_CLK (SYSTEM_CLK),
        .BAUDRATE   (BAUDRATE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_in         (rx_in),
        .ready         (ready),
        .valid         (valid),
        .rx_data       (rx_data),
        .frame_error   (frame_error),
        .overrun_error (overrun_error),
        .parity_error  (parity_error)
    );

    always #5 clk = ~clk;

    // Consumer-side monitor: logs every accepted byte and every error pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (valid) valid_cycles++;
            if (valid && ready) got_q.push_back(rx_data);
            if (frame_error) frame_cnt++;
            if (overrun_error) overrun_cnt++;
            if (parity_error) begin
                parity_cnt++;
                parity_total++;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic clear_mon();
        valid_cycles = 0;
        frame_cnt    = 0;
        overrun_cnt  = 0;
        parity_cnt   = 0;
        got_q.delete();
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (CPS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_parity);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef RX_UART_PARITY_EN
        send_bit((^d) ^ bad_parity);
`else
        if (bad_parity) rx_in = 1'b1;
`endif
        send_bit(stop_bit);
        rx_in = 1'b1;
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 ready = r;
    endtask

    task automatic test_reset();
        @(negedge clk);
        if (valid !== 1'b0) begin $display("FAIL reset_valid: got %b expected 0", valid); n_fail++; end
        n_checks++;
        if (rx_data !== 8'h00) begin $display("FAIL reset_rx_data: got %h expected 00", rx_data); n_fail++; end
        n_checks++;
        if (frame_error !== 1'b0) begin $display("FAIL reset_frame_error: got %b expected 0", frame_error); n_fail++; end
        n_checks++;
        if (overrun_error !== 1'b0) begin $display("FAIL reset_overrun_error: got %b expected 0", overrun_error); n_fail++; end
        n_checks++;
        if (parity_error !== 1'b0) begin $display("FAIL reset_parity_error: got %b expected 0", parity_error); n_fail++; end
        n_checks++;
        @(posedge clk);
        #1 reset = 1'b0;
        clear_mon();
        idle(20);
        if (valid_cycles !== 0) begin $display("FAIL idle_after_reset: valid cycles %0d expected 0", valid_cycles); n_fail++; end
        n_checks++;
    endtask

    task automatic test_single();
        clear_mon();
        send_frame(8'h55, 1'b1, 1'b0);
        idle(6);
        if (got_q.size() !== 1) begin $display("FAIL single_count: got %0d bytes expected 1", got_q.size()); n_fail++; end
        else if (got_q[0] !== 8'h55) begin $display("FAIL single_data: got %h expected 55", got_q[0]); n_fail++; end
        n_checks++;
        if (valid_cycles !== 1) begin $display("FAIL single_valid_width: got %0d cycles expected 1", valid_cycles); n_fail++; end
        n_checks++;
        if (frame_cnt + overrun_cnt + parity_cnt !== 0) begin
            $display("FAIL single_errors: got %0d/%0d/%0d expected 0/0/0", frame_cnt, overrun_cnt, parity_cnt); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        clear_mon();
        exp_q = '{8'hA5, 8'h3C};
        send_frame(8'hA5, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(6);
        if (got_q.size() !== 2) begin $display("FAIL b2b_count: got %0d bytes expected 2", got_q.size()); n_fail++; end
        n_checks++;
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin $display("FAIL b2b_data%0d: got %h expected %h", i, got_q[i], exp_q[i]); n_fail++; end
            n_checks++;
        end
        if (overrun_cnt !== 0 || frame_cnt !== 0) begin
            $display("FAIL b2b_errors: overrun %0d frame %0d expected 0 0", overrun_cnt, frame_cnt); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_glitch();
        clear_mon();
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        idle(8);
        if (valid_cycles !== 0 || frame_cnt !== 0) begin
            $display("FAIL glitch_quiet: valid cycles %0d frame %0d expected 0 0", valid_cycles, frame_cnt); n_fail++;
        end
        n_checks++;
        send_frame(8'h96, 1'b1, 1'b0);
        idle(6);
        if (got_q.size() !== 1) begin $display("FAIL glitch_recover_count: got %0d bytes expected 1", got_q.size()); n_fail++; end
        else if (got_q[0] !== 8'h96) begin $display("FAIL glitch_recover_data: got %h expected 96", got_q[0]); n_fail++; end
        n_checks++;
    endtask

    task automatic test_frame_error();
        clear_mon();
        send_frame(8'h81, 1'b0, 1'b0);
        rx_in = 1'b0;
        repeat (30) @(negedge clk);
        idle(20);
        if (frame_cnt !== 1) begin $display("FAIL frame_err_count: got %0d pulses expected 1", frame_cnt); n_fail++; end
        n_checks++;
        if (valid_cycles !== 0) begin $display("FAIL frame_err_no_valid: got %0d valid cycles expected 0", valid_cycles); n_fail++; end
        n_checks++;
        send_frame(8'h42, 1'b1, 1'b0);
        idle(6);
        if (got_q.size() !== 1) begin $display("FAIL frame_err_next_count: got %0d bytes expected 1", got_q.size()); n_fail++; end
        else if (got_q[0] !== 8'h42) begin $display("FAIL frame_err_next_data: got %h expected 42", got_q[0]); n_fail++; end
        n_checks++;
        if (frame_cnt !== 1) begin $display("FAIL frame_err_total: got %0d pulses expected 1", frame_cnt); n_fail++; end
        n_checks++;
    endtask

    task automatic test_overrun();
        clear_mon();
        set_ready(1'b0);
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        idle(6);
        if (valid !== 1'b1) begin $display("FAIL overrun_valid_held: got %b expected 1", valid); n_fail++; end
        n_checks++;
        if (rx_data !== 8'h11) begin $display("FAIL overrun_data_kept: got %h expected 11", rx_data); n_fail++; end
        n_checks++;
        if (overrun_cnt !== 1) begin $display("FAIL overrun_pulses: got %0d expected 1", overrun_cnt); n_fail++; end
        n_checks++;
        set_ready(1'b1);
        @(negedge clk);
        @(negedge clk);
        if (valid !== 1'b0) begin $display("FAIL overrun_valid_drop: got %b expected 0", valid); n_fail++; end
        n_checks++;
        if (got_q.size() !== 1) begin $display("FAIL overrun_consumed_count: got %0d expected 1", got_q.size()); n_fail++; end
        else if (got_q[0] !== 8'h11) begin $display("FAIL overrun_consumed_data: got %h expected 11", got_q[0]); n_fail++; end
        n_checks++;
    endtask

    task automatic test_reset_midframe();
        clear_mon();
        rx_in = 1'b0;
        repeat (CPS) @(negedge clk);
        rx_in = 1'b1;
        repeat (4 * CPS + CPS / 2) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if ({valid, rx_data, frame_error, overrun_error, parity_error} !== 12'h000) begin
                $display("FAIL midreset_outputs: got valid %b data %h errs %b%b%b expected all 0",
                         valid, rx_data, frame_error, overrun_error, parity_error);
                n_fail++;
            end
            n_checks++;
        end
        @(posedge clk);
        #1 reset = 1'b0;
        idle(25);
        if (valid_cycles !== 0 || frame_cnt !== 0) begin
            $display("FAIL midreset_spurious: valid cycles %0d frame %0d expected 0 0", valid_cycles, frame_cnt); n_fail++;
        end
        n_checks++;
        send_frame(8'h0F, 1'b1, 1'b0);
        idle(6);
        if (got_q.size() !== 1) begin $display("FAIL midreset_count: got %0d bytes expected 1", got_q.size()); n_fail++; end
        else if (got_q[0] !== 8'h0F) begin $display("FAIL midreset_data: got %h expected 0f", got_q[0]); n_fail++; end
        n_checks++;
    endtask

    task automatic test_parity();
`ifdef RX_UART_PARITY_EN
        clear_mon();
        send_frame(8'h0F, 1'b1, 1'b1);
        idle(6);
        if (parity_cnt !== 1) begin $display("FAIL parity_pulse: got %0d expected 1", parity_cnt); n_fail++; end
        n_checks++;
        if (got_q.size() !== 1) begin $display("FAIL parity_count: got %0d bytes expected 1", got_q.size()); n_fail++; end
        else if (got_q[0] !== 8'h0F) begin $display("FAIL parity_data: got %h expected 0f", got_q[0]); n_fail++; end
        n_checks++;
        if (frame_cnt !== 0) begin $display("FAIL parity_frame: got %0d expected 0", frame_cnt); n_fail++; end
        n_checks++;
`else
        if (parity_total !== 0) begin $display("FAIL parity_tied_low: got %0d pulses expected 0", parity_total); n_fail++; end
        n_checks++;
`endif
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        clear_mon();
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1, 1'b0);
            idle($urandom_range(0, 12));
        end
        idle(6);
        if (got_q.size() !== exp_q.size()) begin
            $display("FAIL random_count: got %0d bytes expected %0d", got_q.size(), exp_q.size()); n_fail++;
        end
        n_checks++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin $display("FAIL random_data%0d: got %h expected %h", i, got_q[i], exp_q[i]); n_fail++; end
            n_checks++;
        end
        if (frame_cnt + overrun_cnt + parity_cnt !== 0) begin
            $display("FAIL random_errors: got %0d/%0d/%0d expected 0/0/0", frame_cnt, overrun_cnt, parity_cnt); n_fail++;
        end
        n_checks++;
    endtask

    initial begin
        reset = 1'b1;
        rx_in = 1'b1;
        ready = 1'b1;
        clear_mon();
        repeat (3) @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_reset_midframe();
        test_random();
        test_parity();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
